// File: rtl/ula_ctrl_seq.sv
// ---------------------------------------------------------------------------
// ula_ctrl_seq
//
// Registered ALU control decoder with issue and multi-cycle sequencing.
// Turns opcode/funct/opULA into the ALU operation code. A mult/div issue
// pulses a start to the iterative mult/div unit. It also holds the pipeline
// for a fixed number of cycles, and pulses done in the last of those cycles.
//
// Parameters:
//   CTRL_W  - width of controle (>= 5)
//   MUL_LAT - stall cycles for mult/multi (>= 1)
//   DIV_LAT - stall cycles for div/divi (>= 1)
//   CNT_W   - down-counter width, 2^CNT_W >= max(MUL_LAT, DIV_LAT)
//
// Ports:
//   clk        - system clock, rising edge
//   rst_n      - synchronous active-low reset
//   valid_in   - instruction issue strobe
//   opcode     - instruction opcode (6 bits)
//   funct      - R-type function field (6 bits)
//   opULA      - override from the main control unit (2 bits)
//   flush      - abort the current or pending operation
//   controle   - ALU operation code (registered)
//   ctrl_valid - pulse: controle was written by an issue
//   start      - pulse to the mult/div unit
//   stall      - pipeline hold
//   done       - pulse in the last stall cycle
//   illegal    - pulse: the issued encoding is undefined
// ---------------------------------------------------------------------------
module ula_ctrl_seq #(
  parameter int CTRL_W  = 5,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic [5:0]        opcode,
  input  logic [5:0]        funct,
  input  logic [1:0]        opULA,
  input  logic              flush,
  output logic [CTRL_W-1:0] controle,
  output logic              ctrl_valid,
  output logic              start,
  output logic              stall,
  output logic              done,
  output logic              illegal
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } stateT;

  // ALU operation codes, zero-extended to CTRL_W when written.
  localparam logic [4:0] C_ADD  = 5'd0;
  localparam logic [4:0] C_SUB  = 5'd1;
  localparam logic [4:0] C_MUL  = 5'd2;
  localparam logic [4:0] C_DIV  = 5'd3;
  localparam logic [4:0] C_AND  = 5'd4;
  localparam logic [4:0] C_OR   = 5'd5;
  localparam logic [4:0] C_NAND = 5'd6;
  localparam logic [4:0] C_NOR  = 5'd7;
  localparam logic [4:0] C_BEQ  = 5'd8;
  localparam logic [4:0] C_BNE  = 5'd9;
  localparam logic [4:0] C_BGT  = 5'd10;
  localparam logic [4:0] C_BLT  = 5'd11;
  localparam logic [4:0] C_SLT  = 5'd12;
  localparam logic [4:0] C_SLE  = 5'd13;
  localparam logic [4:0] C_SGE  = 5'd14;

  // The counter is loaded with LAT-1. Stall then covers LAT cycles, and done
  // lands in the cycle where the counter reads zero.
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  stateT             r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [CTRL_W-1:0] r_controle;
  logic              r_ctrlValid;
  logic              r_start;
  logic              r_stall;
  logic              r_done;
  logic              r_illegal;

  logic              w_write;
  logic              w_illegal;
  logic [4:0]        w_base;
  logic [CTRL_W-1:0] w_code;
  logic              w_isMulDiv;
  logic              w_isDiv;
  logic [CNT_W-1:0]  w_latCnt;

  // Decode the current instruction fields.
  // Priority is opULA override, then the opcode, then the R-type funct.
  // w_write is cleared for holds: non-ALU opcodes and undefined encodings.
  always_comb begin
    w_write    = 1'b0;
    w_illegal  = 1'b0;
    w_base     = C_ADD;
    w_code     = '0;
    w_isMulDiv = 1'b0;
    w_isDiv    = 1'b0;
    if (opULA != 2'b00) begin
      w_write = 1'b1;
      case (opULA)
        2'b01:   w_code = '0;
        2'b10:   w_code = '1;
        default: w_code = {{(CTRL_W-1){1'b1}}, 1'b0};
      endcase
    end else if (opcode != 6'h00) begin
      w_write = 1'b1;
      case (opcode)
        6'h01: w_base = C_ADD;
        6'h02: w_base = C_SUB;
        6'h03: begin w_base = C_DIV; w_isMulDiv = 1'b1; w_isDiv = 1'b1; end
        6'h04: begin w_base = C_MUL; w_isMulDiv = 1'b1; end
        6'h05: w_base = C_AND;
        6'h06: w_base = C_OR;
        6'h07: w_base = C_NOR;
        6'h08: w_base = C_SLE;
        6'h09: w_base = C_SLT;
        6'h0A: w_base = C_BEQ;
        6'h0B: w_base = C_BNE;
        6'h0C: w_base = C_BLT;
        6'h0D: w_base = C_BGT;
        default: begin
          // 0x0E..0x17 are valid non-ALU opcodes, so they are held silently.
          w_write   = 1'b0;
          w_illegal = (opcode > 6'h17);
        end
      endcase
      w_code = CTRL_W'(w_base);
    end else begin
      w_write = 1'b1;
      case (funct)
        6'h00: w_base = C_ADD;
        6'h01: w_base = C_SUB;
        6'h02: begin w_base = C_MUL; w_isMulDiv = 1'b1; end
        6'h03: begin w_base = C_DIV; w_isMulDiv = 1'b1; w_isDiv = 1'b1; end
        6'h04: w_base = C_AND;
        6'h05: w_base = C_OR;
        6'h06: w_base = C_NAND;
        6'h07: w_base = C_NOR;
        6'h08: w_base = C_SLE;
        6'h09: w_base = C_SLT;
        6'h0A: w_base = C_SGE;
        default: begin
          w_write   = 1'b0;
          w_illegal = 1'b1;
        end
      endcase
      w_code = CTRL_W'(w_base);
    end
  end

  assign w_latCnt = w_isDiv ? DIV_CNT : MUL_CNT;

  // Issue/stall sequencer.
  // IDLE accepts an issue unless flush is high. A mult/div issue goes to WAIT.
  // WAIT counts down and ignores valid_in. It leaves after the zero-count
  // cycle, or at once on flush, and controle is held throughout.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_controle  <= '0;
      r_ctrlValid <= 1'b0;
      r_start     <= 1'b0;
      r_stall     <= 1'b0;
      r_done      <= 1'b0;
      r_illegal   <= 1'b0;
    end else begin
      r_ctrlValid <= 1'b0;
      r_start     <= 1'b0;
      r_illegal   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_stall <= 1'b0;
          r_done  <= 1'b0;
          if (valid_in && !flush) begin
            r_illegal <= w_illegal;
            if (w_write) begin
              r_controle  <= w_code;
              r_ctrlValid <= 1'b1;
            end
            if (w_isMulDiv) begin
              r_start <= 1'b1;
              r_stall <= 1'b1;
              r_cnt   <= w_latCnt;
              // With a latency of 1, done coincides with start.
              r_done  <= (w_latCnt == '0);
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (flush || r_cnt == '0) begin
            r_stall <= 1'b0;
            r_done  <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_IDLE;
          end else begin
            r_cnt  <= r_cnt - CNT_W'(1);
            r_done <= (r_cnt == CNT_W'(1));
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign controle   = r_controle;
  assign ctrl_valid = r_ctrlValid;
  assign start      = r_start;
  assign stall      = r_stall;
  assign done       = r_done;
  assign illegal    = r_illegal;

endmodule

// File: tb/tb_ula_ctrl_seq.sv
// ---------------------------------------------------------------------------
// tb_ula_ctrl_seq
//
// Self-checking bench for ula_ctrl_seq. It drives two instances from the
// same stimulus:
//   dutA - CTRL_W=5, MUL_LAT=4, DIV_LAT=8 (defaults)
//   dutB - CTRL_W=6, MUL_LAT=1, DIV_LAT=3
// Outputs are packed as {controle (8b), ctrl_valid, start, stall, done, illegal}.
// ---------------------------------------------------------------------------
module tb_ula_ctrl_seq;

  logic       clk;
  logic       rst_n;
  logic       valid_in;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic [1:0] opULA;
  logic       flush;

  logic [4:0] ctrlA;
  logic       cvA, stA, slA, dnA, ilA;
  logic [5:0] ctrlB;
  logic       cvB, stB, slB, dnB, ilB;

  int testsRun;
  int testsFailed;

  ula_ctrl_seq #(.CTRL_W(5), .MUL_LAT(4), .DIV_LAT(8), .CNT_W(4)) dutA (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode),
    .funct(funct), .opULA(opULA), .flush(flush), .controle(ctrlA),
    .ctrl_valid(cvA), .start(stA), .stall(slA), .done(dnA), .illegal(ilA)
  );

  ula_ctrl_seq #(.CTRL_W(6), .MUL_LAT(1), .DIV_LAT(3), .CNT_W(2)) dutB (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .opcode(opcode),
    .funct(funct), .opULA(opULA), .flush(flush), .controle(ctrlB),
    .ctrl_valid(cvB), .start(stB), .stall(slB), .done(dnB), .illegal(ilB)
  );

  logic [12:0] actA;
  logic [12:0] actB;
  assign actA = {3'b000, ctrlA, cvA, stA, slA, dnA, ilA};
  assign actB = {2'b00, ctrlB, cvB, stB, slB, dnB, ilB};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level reference model. busyLeft counts the stall cycles
  // still to come, including the current cycle.
  typedef struct {
    int controle;
    int busyLeft;
    bit ctrlValid;
    bit start;
    bit illegal;
  } modelT;

  modelT mA, mB;

  int opTable[14]   = '{-1, 0, 1, 3, 2, 4, 5, 7, 13, 12, 8, 9, 11, 10};
  int functTable[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 13, 12, 14};

  function automatic modelT modelStep(modelT m, bit rstN, bit v, bit fl,
                                      int op, int fn, int opU,
                                      int ctrlW, int mulLat, int divLat);
    modelT n;
    int code;
    int allOnes;
    bit ill;
    n = m;
    n.ctrlValid = 0;
    n.start = 0;
    n.illegal = 0;
    code = -1;
    ill = 0;
    allOnes = (1 << ctrlW) - 1;
    if (!rstN) begin
      n.controle = 0;
      n.busyLeft = 0;
    end else if (m.busyLeft > 0) begin
      n.busyLeft = fl ? 0 : m.busyLeft - 1;
    end else if (v && !fl) begin
      if (opU == 1) code = 0;
      else if (opU == 2) code = allOnes;
      else if (opU == 3) code = allOnes - 1;
      else if (op != 0) begin
        if (op <= 13) code = opTable[op];
        else if (op > 'h17) ill = 1;
      end else if (fn <= 10) code = functTable[fn];
      else ill = 1;
      n.illegal = ill;
      if (code >= 0) begin
        n.controle = code;
        n.ctrlValid = 1;
        if (opU == 0 && (code == 2 || code == 3)) begin
          n.start = 1;
          n.busyLeft = (code == 2) ? mulLat : divLat;
        end
      end
    end
    return n;
  endfunction

  function automatic logic [12:0] packModel(modelT m);
    return {8'(m.controle), m.ctrlValid, m.start, m.busyLeft > 0,
            m.busyLeft == 1, m.illegal};
  endfunction

  // Drive one cycle of inputs, advance the models over the same edge, then
  // wait until just after that edge so outputs are sampled away from it.
  task automatic applyStimulus(input bit rstN, input bit v, input logic [5:0] op,
                               input logic [5:0] fn, input logic [1:0] opU,
                               input bit fl);
    rst_n    = rstN;
    valid_in = v;
    opcode   = op;
    funct    = fn;
    opULA    = opU;
    flush    = fl;
    mA = modelStep(mA, rstN, v, fl, int'(op), int'(fn), int'(opU), 5, 4, 8);
    mB = modelStep(mB, rstN, v, fl, int'(op), int'(fn), int'(opU), 6, 1, 3);
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [12:0] act,
                             input logic [12:0] exp);
    testsRun++;
    if (act !== exp) begin
      testsFailed++;
      $display("[TB] FAIL %s: got controle=%0d flags(cv,st,sl,dn,il)=%b, expected controle=%0d flags=%b",
               name, act[12:5], act[4:0], exp[12:5], exp[4:0]);
    end
  endtask

  typedef struct {
    logic       v;
    logic [5:0] op;
    logic [5:0] fn;
    logic [1:0] opU;
    logic       fl;
    logic [7:0] expCtl;
    logic [4:0] expFlags;
  } vecT;

  vecT vecs[$];

  function automatic void addVec(logic v, logic [5:0] op, logic [5:0] fn,
                                 logic [1:0] opU, logic fl, logic [7:0] ctl,
                                 logic [4:0] flags);
    vecT t;
    t.v = v; t.op = op; t.fn = fn; t.opU = opU; t.fl = fl;
    t.expCtl = ctl; t.expFlags = flags;
    vecs.push_back(t);
  endfunction

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    testsRun = 0;
    testsFailed = 0;
    mA = '{0, 0, 0, 0, 0};
    mB = '{0, 0, 0, 0, 0};

    // Single-cycle vectors for dutA, applied back to back from reset.
    // Flags are {ctrl_valid, start, stall, done, illegal}.
    addVec(1, 6'h00, 6'h01, 2'b00, 0,  1, 5'b10000); // sub
    addVec(1, 6'h05, 6'h00, 2'b00, 0,  4, 5'b10000); // andi
    addVec(0, 6'h06, 6'h00, 2'b00, 0,  4, 5'b00000); // no issue
    addVec(1, 6'h08, 6'h00, 2'b00, 0, 13, 5'b10000); // slei
    addVec(1, 6'h09, 6'h00, 2'b00, 0, 12, 5'b10000); // slti
    addVec(1, 6'h0A, 6'h00, 2'b00, 0,  8, 5'b10000); // beq
    addVec(1, 6'h0B, 6'h00, 2'b00, 0,  9, 5'b10000); // bne
    addVec(1, 6'h0C, 6'h00, 2'b00, 0, 11, 5'b10000); // blt
    addVec(1, 6'h0D, 6'h00, 2'b00, 0, 10, 5'b10000); // bgt
    addVec(1, 6'h15, 6'h00, 2'b00, 0, 10, 5'b00000); // jmp: hold
    addVec(1, 6'h20, 6'h00, 2'b00, 0, 10, 5'b00001); // undefined opcode
    addVec(1, 6'h18, 6'h00, 2'b00, 0, 10, 5'b00001); // first undefined
    addVec(1, 6'h17, 6'h00, 2'b00, 0, 10, 5'b00000); // last non-ALU
    addVec(1, 6'h0E, 6'h00, 2'b00, 0, 10, 5'b00000); // first non-ALU
    addVec(1, 6'h00, 6'h0B, 2'b00, 0, 10, 5'b00001); // undefined funct
    addVec(1, 6'h00, 6'h0A, 2'b00, 0, 14, 5'b10000); // sge
    addVec(1, 6'h00, 6'h08, 2'b00, 0, 13, 5'b10000); // sle
    addVec(1, 6'h00, 6'h09, 2'b00, 0, 12, 5'b10000); // slt
    addVec(1, 6'h00, 6'h06, 2'b00, 0,  6, 5'b10000); // NAND
    addVec(1, 6'h00, 6'h07, 2'b00, 0,  7, 5'b10000); // NOR
    addVec(1, 6'h07, 6'h00, 2'b00, 0,  7, 5'b10000); // nori
    addVec(1, 6'h02, 6'h00, 2'b00, 0,  1, 5'b10000); // subi
    addVec(1, 6'h04, 6'h00, 2'b10, 0, 31, 5'b10000); // opULA=10 beats multi
    addVec(1, 6'h00, 6'h02, 2'b11, 0, 30, 5'b10000); // opULA=11 beats mult
    addVec(1, 6'h03, 6'h00, 2'b01, 0,  0, 5'b10000); // opULA=01 beats divi
    addVec(1, 6'h06, 6'h00, 2'b00, 1,  0, 5'b00000); // flush beats valid
    addVec(1, 6'h06, 6'h00, 2'b00, 0,  5, 5'b10000); // ori
    addVec(1, 6'h00, 6'h04, 2'b00, 0,  4, 5'b10000); // AND
    addVec(1, 6'h00, 6'h05, 2'b00, 0,  5, 5'b10000); // OR
    addVec(1, 6'h01, 6'h00, 2'b00, 0,  0, 5'b10000); // addi
    addVec(0, 6'h00, 6'h01, 2'b00, 1,  0, 5'b00000); // idle flush

    // Reset held for two edges with an addi issue pending.
    applyStimulus(0, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("reset1_A", actA, 13'd0);
    checkOutput("reset1_B", actB, 13'd0);
    applyStimulus(0, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("reset2_A", actA, 13'd0);
    checkOutput("reset2_B", actB, 13'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(1, vecs[i].v, vecs[i].op, vecs[i].fn, vecs[i].opU, vecs[i].fl);
      checkOutput($sformatf("vec%0d", i), actA, {vecs[i].expCtl, vecs[i].expFlags});
    end

    // R/mult: dutA stalls 4 cycles, dutB (latency 1) has start/stall/done
    // together. A held addi is ignored while stalled.
    applyStimulus(1, 1, 6'h00, 6'h02, 2'b00, 0);
    checkOutput("mul_c1_A", actA, {8'd2, 5'b11100});
    checkOutput("mul_c1_B", actB, {8'd2, 5'b11110});
    applyStimulus(1, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("mul_c2_A", actA, {8'd2, 5'b00100});
    checkOutput("mul_c2_B", actB, {8'd2, 5'b00000});
    applyStimulus(1, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("mul_c3_A", actA, {8'd2, 5'b00100});
    checkOutput("mul_c3_B", actB, {8'd0, 5'b10000});
    applyStimulus(1, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("mul_c4_A", actA, {8'd2, 5'b00110});
    applyStimulus(1, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("mul_c5_A", actA, {8'd2, 5'b00000});
    applyStimulus(1, 1, 6'h01, 6'h00, 2'b00, 0);
    checkOutput("mul_c6_A", actA, {8'd0, 5'b10000});

    // divi aborted by flush during cycle 3.
    applyStimulus(1, 1, 6'h03, 6'h00, 2'b00, 0);
    checkOutput("div_c1_A", actA, {8'd3, 5'b11100});
    checkOutput("div_c1_B", actB, {8'd3, 5'b11100});
    applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 0);
    checkOutput("div_c2_A", actA, {8'd3, 5'b00100});
    checkOutput("div_c2_B", actB, {8'd3, 5'b00100});
    applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 0);
    checkOutput("div_c3_A", actA, {8'd3, 5'b00100});
    checkOutput("div_c3_B", actB, {8'd3, 5'b00110});
    applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 1);
    checkOutput("div_c4_A", actA, {8'd3, 5'b00000});
    checkOutput("div_c4_B", actB, {8'd3, 5'b00000});
    for (int i = 5; i < 11; i++) begin
      applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 0);
      checkOutput($sformatf("div_c%0d_A", i), actA, {8'd3, 5'b00000});
    end

    // opULA overrides on the 6-bit instance.
    applyStimulus(1, 1, 6'h00, 6'h00, 2'b10, 0);
    checkOutput("opula10_B", actB, {8'd63, 5'b10000});
    checkOutput("opula10_A", actA, {8'd31, 5'b10000});
    applyStimulus(1, 1, 6'h00, 6'h00, 2'b11, 0);
    checkOutput("opula11_B", actB, {8'd62, 5'b10000});
    applyStimulus(1, 1, 6'h04, 6'h00, 2'b01, 0);
    checkOutput("opula01_B", actB, {8'd0, 5'b10000});
    checkOutput("opula01_A", actA, {8'd0, 5'b10000});
    applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 0);
    checkOutput("opula01_idle_A", actA, {8'd0, 5'b00000});

    // Reset during WAIT: no done pulse, everything cleared.
    applyStimulus(1, 1, 6'h04, 6'h00, 2'b00, 0);
    checkOutput("rstw_c1_A", actA, {8'd2, 5'b11100});
    applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 0);
    checkOutput("rstw_c2_A", actA, {8'd2, 5'b00100});
    applyStimulus(0, 0, 6'h00, 6'h00, 2'b00, 0);
    checkOutput("rstw_c3_A", actA, 13'd0);
    checkOutput("rstw_c3_B", actB, 13'd0);
    applyStimulus(1, 0, 6'h00, 6'h00, 2'b00, 0);
    checkOutput("rstw_c4_A", actA, 13'd0);

    // Randomised traffic against the reference model on both instances.
    for (int i = 0; i < 1500; i++) begin
      bit rN, v, fl;
      logic [5:0] op, fn;
      logic [1:0] opU;
      int r;
      rN = ($urandom_range(0, 99) != 0);
      v  = ($urandom_range(0, 9) < 7);
      fl = ($urandom_range(0, 99) < 8);
      r  = $urandom_range(0, 9);
      if (r < 4) op = 6'h00;
      else if (r < 8) op = 6'($urandom_range(1, 13));
      else op = 6'($urandom_range(14, 63));
      fn  = 6'($urandom_range(0, 12));
      opU = ($urandom_range(0, 7) < 6) ? 2'b00 : 2'($urandom_range(1, 3));
      applyStimulus(rN, v, op, fn, opU, fl);
      checkOutput($sformatf("rand%0d_A", i), actA, packModel(mA));
      checkOutput($sformatf("rand%0d_B", i), actB, packModel(mB));
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
